// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the write-back sequencer.
//   XLEN       - result / register-file data width
//   REG_ADDR_W - register address width (32 architectural registers)
//   NUM_REGS   - number of architectural registers
//   wb_req_t   - one pending write: destination register plus data
package wb_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

   // One-hot register mask for rd; all-zero when en is low.
   function automatic logic [NUM_REGS-1:0] reg_mask(input logic en,
                                                   input logic [REG_ADDR_W-1:0] rd);
      logic [NUM_REGS-1:0] m;
      m = {NUM_REGS{1'b0}};
      if (en) begin
         m[rd] = 1'b1;
      end else begin
         m = {NUM_REGS{1'b0}};
      end
      return m;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO holding load responses awaiting write-back.
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   push_i, data_i  - enqueue request (ignored when full)
//   pop_i           - dequeue head (ignored when empty)
//   head_o          - current head entry (valid when !empty_o)
//   full_o, empty_o - occupancy flags, derived from the pointers only
module wb_fifo
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic    clk_i,
   input  logic    rst_ni,
   input  logic    push_i,
   input  wb_req_t data_i,
   input  logic    pop_i,
   output wb_req_t head_o,
   output logic    full_o,
   output logic    empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   wb_req_t     mem_q [DEPTH];
   logic        push_ok_s;
   logic        pop_ok_s;

   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign push_ok_s = push_i && !full_o;
   assign pop_ok_s  = pop_i && !empty_o;
   assign head_o    = mem_q[rd_ptr_q[AW-1:0]];

   // Next-state pointer arithmetic (modular wrap).
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // Pointer registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= {(AW+1){1'b0}};
         rd_ptr_q <= {(AW+1){1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage; contents are only ever read behind a valid pointer, so no reset.
   always_ff @(posedge clk_i) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= data_i;
      end
   end

endmodule

// File: rtl/wb_writer_chk.sv
// wb_writer_chk: upstream-contract checks for wb_writer (simulation only).
//   clk, rst_n            - clock and reset of the checked block
//   alu_valid, alu_rd     - ALU write request
//   ld_issue, ld_issue_rd - load issue
//   mem_valid, mem_rd     - load response
//   pending               - scoreboard state
//   clr_mask              - registers being cleared this cycle (FIFO head selected)
module wb_writer_chk (
   input logic        clk,
   input logic        rst_n,
   input logic        alu_valid,
   input logic [4:0]  alu_rd,
   input logic        ld_issue,
   input logic [4:0]  ld_issue_rd,
   input logic        mem_valid,
   input logic [4:0]  mem_rd,
   input logic [31:0] pending,
   input logic [31:0] clr_mask
);

   // Sample contract properties on every active edge out of reset.
   always @(posedge clk) begin
      if (rst_n) begin
         // A re-issue is legal only when the previous load to rd retires this cycle.
         assert (!(ld_issue && pending[ld_issue_rd] && !clr_mask[ld_issue_rd]))
            else $error("contract: ld_issue to pending rd %0d", ld_issue_rd);
         assert (!(alu_valid && pending[alu_rd]))
            else $error("contract: alu write to pending rd %0d", alu_rd);
         assert (!(mem_valid && !pending[mem_rd]))
            else $error("contract: mem response for non-pending rd %0d", mem_rd);
      end
   end

endmodule

// File: rtl/wb_writer.sv
// wb_writer: write-back sequencer for the 32x32 register file.
//   clk, rst_n                     - clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data      - single-cycle ALU result (always accepted)
//   ld_issue/ld_issue_rd           - load issue, marks rd pending
//   mem_valid/mem_rd/mem_data      - load response, accepted when mem_ready
//   mem_ready                      - FIFO not full
//   RegWEn/AddrD/DataD             - registered register-file write port
//   pending                        - per-register outstanding-load scoreboard
// XLEN must match wb_pkg::XLEN, which sizes the buffered payload.
module wb_writer
   import wb_pkg::*;
#(
   parameter int unsigned XLEN  = wb_pkg::XLEN,
   parameter int unsigned DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            ld_issue,
   input  logic [4:0]      ld_issue_rd,
   input  logic            mem_valid,
   output logic            mem_ready,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN-1:0] mem_data,
   output logic            RegWEn,
   output logic [4:0]      AddrD,
   output logic [XLEN-1:0] DataD,
   output logic [31:0]     pending
);

   wb_req_t         push_req_s;
   wb_req_t         head_s;
   logic            fifo_full_s;
   logic            fifo_empty_s;
   logic            sel_fifo_s;
   logic            sel_any_s;
   logic [4:0]      sel_rd_s;
   logic [XLEN-1:0] sel_data_s;
   logic [31:0]     set_mask_s;
   logic [31:0]     clr_mask_s;

   logic            wen_q,     wen_d;
   logic [4:0]      addr_q,    addr_d;
   logic [XLEN-1:0] data_q,    data_d;
   logic [31:0]     pending_q, pending_d;

   assign push_req_s.rd   = mem_rd;
   assign push_req_s.data = mem_data;
   assign mem_ready       = !fifo_full_s;

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .push_i  (mem_valid),
      .data_i  (push_req_s),
      .pop_i   (sel_fifo_s),
      .head_o  (head_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s)
   );

   // Arbiter: ALU first, then FIFO head; drives the next write-port values.
   always_comb begin
      sel_fifo_s = 1'b0;
      sel_any_s  = 1'b0;
      sel_rd_s   = 5'd0;
      sel_data_s = {XLEN{1'b0}};
      if (alu_valid) begin
         sel_any_s  = 1'b1;
         sel_rd_s   = alu_rd;
         sel_data_s = alu_data;
      end else if (!fifo_empty_s) begin
         sel_fifo_s = 1'b1;
         sel_any_s  = 1'b1;
         sel_rd_s   = head_s.rd;
         sel_data_s = head_s.data;
      end else begin
         sel_any_s  = 1'b0;
      end

      // rd==0 selections are consumed but never written; address/data hold.
      wen_d  = sel_any_s && (sel_rd_s != 5'd0);
      addr_d = addr_q;
      data_d = data_q;
      if (wen_d) begin
         addr_d = sel_rd_s;
         data_d = sel_data_s;
      end else begin
         addr_d = addr_q;
         data_d = data_q;
      end
   end

   // Scoreboard next state: a set in the same cycle as a clear wins.
   always_comb begin
      set_mask_s = reg_mask(ld_issue && (ld_issue_rd != 5'd0), ld_issue_rd);
      clr_mask_s = reg_mask(sel_fifo_s, head_s.rd);
      pending_d  = set_mask_s | (pending_q & ~clr_mask_s);
      pending_d[0] = 1'b0;
   end

   // Registered write port and scoreboard.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wen_q     <= 1'b0;
         addr_q    <= 5'd0;
         data_q    <= {XLEN{1'b0}};
         pending_q <= 32'd0;
      end else begin
         wen_q     <= wen_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         pending_q <= pending_d;
      end
   end

   assign RegWEn  = wen_q;
   assign AddrD   = addr_q;
   assign DataD   = data_q;
   assign pending = pending_q;

   wb_writer_chk u_chk (
      .clk         (clk),
      .rst_n       (rst_n),
      .alu_valid   (alu_valid),
      .alu_rd      (alu_rd),
      .ld_issue    (ld_issue),
      .ld_issue_rd (ld_issue_rd),
      .mem_valid   (mem_valid),
      .mem_rd      (mem_rd),
      .pending     (pending_q),
      .clr_mask    (clr_mask_s)
   );

endmodule

// File: tb/tb_wb_writer.sv
// tb_wb_writer: directed self-checking bench for wb_writer (DEPTH=4).
module tb_wb_writer;

   logic        clk;
   logic        rst_n;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_issue;
   logic [4:0]  ld_issue_rd;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        RegWEn;
   logic [4:0]  AddrD;
   logic [31:0] DataD;
   logic [31:0] pending;

   int n_checks;
   int n_fail;

   wb_writer #(
      .XLEN  (32),
      .DEPTH (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .alu_valid   (alu_valid),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .ld_issue    (ld_issue),
      .ld_issue_rd (ld_issue_rd),
      .mem_valid   (mem_valid),
      .mem_ready   (mem_ready),
      .mem_rd      (mem_rd),
      .mem_data    (mem_data),
      .RegWEn      (RegWEn),
      .AddrD       (AddrD),
      .DataD       (DataD),
      .pending     (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
         else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
         end
   endtask

   initial begin
      int m;
      int w;
      int si;
      int wi;
      logic [31:0] exp_data;

      n_checks = 0;
      n_fail   = 0;
      rst_n = 1'b0;
      alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
      ld_issue = 1'b0; ld_issue_rd = 5'd0;
      mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;

      // Reset state
      tick(); tick();
      chk("rst_wen", {63'd0, RegWEn}, 64'd0);
      chk("rst_addr", {59'd0, AddrD}, 64'd0);
      chk("rst_data", {32'd0, DataD}, 64'd0);
      chk("rst_pending", {32'd0, pending}, 64'd0);
      chk("rst_ready", {63'd0, mem_ready}, 64'd1);
      rst_n = 1'b1;
      tick();
      chk("idle_wen", {63'd0, RegWEn}, 64'd0);

      // ALU write, one-cycle latency
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      tick();
      alu_valid = 1'b0;
      chk("alu_wen", {63'd0, RegWEn}, 64'd1);
      chk("alu_addr", {59'd0, AddrD}, 64'd5);
      chk("alu_data", {32'd0, DataD}, 64'hDEADBEEF);
      // ALU to x0: no write, address/data hold
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h11111111;
      tick();
      alu_valid = 1'b0;
      chk("alu_x0_wen", {63'd0, RegWEn}, 64'd0);
      chk("alu_x0_addr", {59'd0, AddrD}, 64'd5);
      chk("alu_x0_data", {32'd0, DataD}, 64'hDEADBEEF);

      // Load path: issue, respond, write two edges later
      ld_issue = 1'b1; ld_issue_rd = 5'd7;
      tick();
      ld_issue = 1'b0;
      chk("ld_pend_set", {32'd0, pending}, 64'h80);
      mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h12345678;
      tick();
      mem_valid = 1'b0;
      chk("ld_wen_n1", {63'd0, RegWEn}, 64'd0);
      chk("ld_pend_n1", {32'd0, pending}, 64'h80);
      tick();
      chk("ld_wen_n2", {63'd0, RegWEn}, 64'd1);
      chk("ld_addr", {59'd0, AddrD}, 64'd7);
      chk("ld_data", {32'd0, DataD}, 64'h12345678);
      chk("ld_pend_clr", {32'd0, pending}, 64'd0);
      tick();
      chk("ld_wen_done", {63'd0, RegWEn}, 64'd0);

      // Contention: ALU every cycle for 6 cycles, 5 loads to x1..x5
      for (int i = 1; i <= 5; i++) begin
         ld_issue = 1'b1; ld_issue_rd = 5'(i);
         tick();
      end
      ld_issue = 1'b0;
      chk("cont_pending", {32'd0, pending}, 64'h3E);
      m = 0;
      for (int c = 0; c < 6; c++) begin
         alu_valid = 1'b1; alu_rd = 5'(20 + c); alu_data = 32'hA000 + 32'(c);
         mem_valid = (m < 5); mem_rd = 5'(m + 1); mem_data = 32'h100 + 32'(m + 1);
         chk("cont_ready", {63'd0, mem_ready}, {63'd0, (c < 4)});
         if (mem_ready && mem_valid) m++;
         tick();
         chk("cont_alu_addr", {59'd0, AddrD}, 64'(20 + c));
         chk("cont_alu_data", {32'd0, DataD}, 64'hA000 + 64'(c));
      end
      alu_valid = 1'b0;
      w = 0;
      for (int c = 0; c < 20 && w < 5; c++) begin
         mem_valid = (m < 5); mem_rd = 5'(m + 1); mem_data = 32'h100 + 32'(m + 1);
         if (mem_ready && mem_valid) m++;
         tick();
         if (RegWEn) begin
            chk("cont_ld_addr", {59'd0, AddrD}, 64'(w + 1));
            chk("cont_ld_data", {32'd0, DataD}, 64'h100 + 64'(w + 1));
            w++;
         end
      end
      mem_valid = 1'b0;
      chk("cont_ld_count", 64'(w), 64'd5);
      chk("cont_pend_end", {32'd0, pending}, 64'd0);
      chk("cont_ready_end", {63'd0, mem_ready}, 64'd1);

      // Wrap-around: 12 loads through a 4-deep FIFO with ALU bubbles to x25
      for (int i = 1; i <= 12; i++) begin
         ld_issue = 1'b1; ld_issue_rd = 5'(i);
         tick();
      end
      ld_issue = 1'b0;
      chk("wrap_pending", {32'd0, pending}, 64'h1FFE);
      si = 0;
      wi = 0;
      for (int c = 0; c < 100 && wi < 12; c++) begin
         alu_valid = (c % 3 == 1); alu_rd = 5'd25; alu_data = 32'(c);
         mem_valid = (si < 12); mem_rd = 5'(si + 1); mem_data = 32'hC0DE0000 + 32'(si * 32'h111);
         if (mem_ready && mem_valid) si++;
         tick();
         if (RegWEn && AddrD != 5'd25) begin
            exp_data = 32'hC0DE0000 + 32'(wi * 32'h111);
            chk("wrap_addr", {59'd0, AddrD}, 64'(wi + 1));
            chk("wrap_data", {32'd0, DataD}, {32'd0, exp_data});
            wi++;
         end
      end
      alu_valid = 1'b0; mem_valid = 1'b0;
      chk("wrap_count", 64'(wi), 64'd12);
      chk("wrap_pend_end", {32'd0, pending}, 64'd0);

      // Set/clear collision on x9: set wins
      ld_issue = 1'b1; ld_issue_rd = 5'd9;
      tick();
      ld_issue = 1'b0;
      mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
      tick();
      mem_valid = 1'b0;
      ld_issue = 1'b1; ld_issue_rd = 5'd9;
      tick();
      ld_issue = 1'b0;
      chk("coll_wen", {63'd0, RegWEn}, 64'd1);
      chk("coll_addr", {59'd0, AddrD}, 64'd9);
      chk("coll_pending", {32'd0, pending}, 64'h200);
      mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h98;
      tick();
      mem_valid = 1'b0;
      tick();
      chk("coll_data2", {32'd0, DataD}, 64'h98);
      chk("coll_pend_end", {32'd0, pending}, 64'd0);

      // Reset mid-stream: buffered load to x3 must be discarded
      ld_issue = 1'b1; ld_issue_rd = 5'd3;
      tick();
      ld_issue = 1'b0;
      mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h33;
      tick();
      mem_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mrst_wen", {63'd0, RegWEn}, 64'd0);
      chk("mrst_pending", {32'd0, pending}, 64'd0);
      chk("mrst_ready", {63'd0, mem_ready}, 64'd1);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("mrst_no_write", {63'd0, RegWEn}, 64'd0);
      end
      chk("mrst_addr", {59'd0, AddrD}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
